// File: rtl/tt_uart_tx_port_if.sv
`default_nettype none
// ============================================================================
//  Module   : tt_uart_tx_port_if
//  Brief    : Host-side byte handshake and line/status bundle for tt_uart_tx_port.
//  Revision : 1.0  initial release
// ============================================================================
interface tt_uart_tx_port_if #(
    parameter int DEPTH = 4
);
    logic                     ena;
    logic                     wr_valid;
    logic [7:0]               wr_data;
    logic                     wr_ready;
    logic                     tx;
    logic                     busy;
    logic [$clog2(DEPTH):0]   fifo_count;
    logic                     overflow;

    modport master (
        output ena, wr_valid, wr_data,
        input  wr_ready, tx, busy, fifo_count, overflow
    );

    modport slave (
        input  ena, wr_valid, wr_data,
        output wr_ready, tx, busy, fifo_count, overflow
    );
endinterface
`default_nettype wire

// File: rtl/tt_uart_tx_port.sv
`default_nettype none
// ============================================================================
//  Module   : tt_uart_tx_port
//  Brief    : FIFO-buffered 8N1 UART transmitter for the TinyTapeout pin wrapper.
//  Revision : 1.0  initial release
// ============================================================================
module tt_uart_tx_port #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DEPTH        = 4   // must match the DEPTH of the bound interface
) (
    input  logic                clk,
    input  logic                rst,
    tt_uart_tx_port_if.slave    bus
);

    localparam int c_baud_w = $clog2(CLKS_PER_BIT);
    localparam int c_ptr_w  = $clog2(DEPTH);
    localparam int c_cnt_w  = c_ptr_w + 1;

    localparam logic [c_baud_w-1:0] c_baud_last = c_baud_w'(CLKS_PER_BIT - 1);
    localparam logic [c_baud_w-1:0] c_baud_one  = c_baud_w'(1);
    localparam logic [c_ptr_w-1:0]  c_ptr_one   = c_ptr_w'(1);
    localparam logic [c_cnt_w-1:0]  c_cnt_one   = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0]  c_depth     = c_cnt_w'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [c_baud_w-1:0]    r_baud;
    logic [2:0]             r_bit_idx;
    logic [7:0]             r_shift;
    logic                   r_tx;

    logic [7:0]             r_mem [DEPTH];
    logic [c_ptr_w-1:0]     r_wr_ptr;
    logic [c_ptr_w-1:0]     r_rd_ptr;
    logic [c_cnt_w-1:0]     r_count;
    logic                   r_overflow;

    logic                   w_wr_ready;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_fifo_nonempty;
    logic                   w_baud_done;
    logic                   w_tx_next;

    // Ready comes from the registered count only, so a full FIFO refuses a
    // push even on the edge where the FSM pops.
    assign w_wr_ready      = !rst && bus.ena && (r_count < c_depth);
    assign w_push          = bus.wr_valid && w_wr_ready;
    assign w_fifo_nonempty = (r_count != '0);
    assign w_baud_done     = (r_baud == c_baud_last);

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
            if (bus.wr_valid && !w_wr_ready && bus.ena) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_tx_next    = 1'b1;
        case (r_state)
            ST_IDLE: begin
                if (w_fifo_nonempty) begin
                    w_pop        = 1'b1;
                    w_state_next = ST_START;
                end
            end
            ST_START: begin
                w_tx_next = 1'b0;
                if (w_baud_done) begin
                    w_state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                w_tx_next = r_shift[0];
                if (w_baud_done && (r_bit_idx == 3'd7)) begin
                    w_state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                // Chaining straight into START keeps back-to-back frames gapless.
                if (w_baud_done) begin
                    if (w_fifo_nonempty) begin
                        w_pop        = 1'b1;
                        w_state_next = ST_START;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_baud    <= '0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'd0;
            r_tx      <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_tx    <= w_tx_next;

            if ((w_state_next != r_state) || (r_state == ST_IDLE) || w_baud_done) begin
                r_baud <= '0;
            end else begin
                r_baud <= r_baud + c_baud_one;
            end

            if (r_state == ST_START) begin
                r_bit_idx <= 3'd0;
            end else if ((r_state == ST_DATA) && w_baud_done) begin
                r_bit_idx <= r_bit_idx + 3'd1;
            end

            if (w_pop) begin
                r_shift <= r_mem[r_rd_ptr];
            end else if ((r_state == ST_DATA) && w_baud_done) begin
                r_shift <= {1'b0, r_shift[7:1]};
            end
        end
    end

    assign bus.wr_ready   = w_wr_ready;
    assign bus.tx         = r_tx;
    assign bus.busy       = (r_state != ST_IDLE) || w_fifo_nonempty;
    assign bus.fifo_count = r_count;
    assign bus.overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_tt_uart_tx_port.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tt_uart_tx_port
//  Brief    : Scoreboard bench for tt_uart_tx_port (UART line decoder + expected-byte queue).
//  Revision : 1.0  initial release
// ============================================================================
module tb_tt_uart_tx_port;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tt_uart_tx_port_if #(.DEPTH(DEPTH)) bus ();

    tt_uart_tx_port #(
        .CLKS_PER_BIT (CPB),
        .DEPTH        (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          frames   = 0;
    logic [7:0]  exp_q [$];
    int          start_q [$];

    bit          mon_active = 1'b0;
    int          mon_cyc    = 0;
    logic [9:0]  mon_bits;
    logic [7:0]  mon_exp;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Line decoder: samples each bit at its centre and scores whole frames.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            mon_active = 1'b0;
        end else if (!mon_active) begin
            if (bus.tx === 1'b0) begin
                mon_active = 1'b1;
                mon_cyc    = 0;
                start_q.push_back(cyc);
            end
        end else begin
            mon_cyc++;
            if ((mon_cyc % CPB) == (CPB / 2)) begin
                mon_bits[mon_cyc / CPB] = bus.tx;
                if ((mon_cyc / CPB) == 9) begin
                    mon_active = 1'b0;
                    frames++;
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_frame: got frame %03h, required no frame", mon_bits);
                    end else begin
                        mon_exp = exp_q.pop_front();
                        if (mon_bits !== {1'b1, mon_exp, 1'b0}) begin
                            failures++;
                            $display("FAIL frame_data: got frame %03h, required %03h",
                                     mon_bits, {1'b1, mon_exp, 1'b0});
                        end
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, required finish within time limit");
        $fatal(1);
    end

    // ---------------- stimulus helpers ----------------
    task automatic offer(input logic [7:0] d, output bit acc);
        bus.wr_valid = 1'b1;
        bus.wr_data  = d;
        acc          = bus.wr_ready;
        if (acc) exp_q.push_back(d);
    endtask

    task automatic at_cycle(input int c);
        do @(negedge clk); while (cyc < c);
    endtask

    task automatic wait_idle(output bit timed_out);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (((bus.busy !== 1'b0) || mon_active) && (n < 4000));
        timed_out = (n >= 4000);
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_start(output bit timed_out);
        int n = 0;
        while ((start_q.size() == 0) && (n < 200)) begin
            @(negedge clk);
            n++;
        end
        timed_out = (start_q.size() == 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst          = 1'b1;
        bus.wr_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        start_q.delete();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst          = 1'b1;
        bus.ena      = 1'b1;
        bus.wr_valid = 1'b0;
        bus.wr_data  = 8'h00;
        repeat (3) @(negedge clk);
        checks++; if (bus.tx !== 1'b1) begin failures++; $display("FAIL rst_tx: got %b, required 1", bus.tx); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b, required 0", bus.busy); end
        checks++; if (bus.fifo_count !== 3'd0) begin failures++; $display("FAIL rst_count: got %0d, required 0", bus.fifo_count); end
        checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL rst_overflow: got %b, required 0", bus.overflow); end
        checks++; if (bus.wr_ready !== 1'b0) begin failures++; $display("FAIL rst_wr_ready: got %b, required 0", bus.wr_ready); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.wr_ready !== 1'b1) begin failures++; $display("FAIL post_rst_wr_ready: got %b, required 1", bus.wr_ready); end
    endtask

    task automatic test_single();
        bit acc, to;
        int n, f0;
        start_q.delete();
        f0 = frames;
        @(negedge clk);
        offer(8'hA5, acc);
        checks++; if (acc !== 1'b1) begin failures++; $display("FAIL single_accept: got %b, required 1", acc); end
        @(posedge clk);
        #1;
        n = cyc;
        bus.wr_valid = 1'b0;
        at_cycle(n);
        checks++; if (bus.fifo_count !== 3'd1) begin failures++; $display("FAIL single_count_push: got %0d, required 1", bus.fifo_count); end
        at_cycle(n + 1);
        checks++; if (bus.fifo_count !== 3'd0) begin failures++; $display("FAIL single_count_pop: got %0d, required 0", bus.fifo_count); end
        checks++; if ({bus.tx, bus.busy} !== 2'b11) begin failures++; $display("FAIL single_pop_cycle tx/busy: got %b, required 11", {bus.tx, bus.busy}); end
        at_cycle(n + 2);
        checks++; if (bus.tx !== 1'b0) begin failures++; $display("FAIL single_start_edge: got %b, required 0", bus.tx); end
        at_cycle(n + 160);
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL single_busy_end: got %b, required 1", bus.busy); end
        at_cycle(n + 161);
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL single_busy_fall: got %b, required 0", bus.busy); end
        wait_idle(to);
        checks++; if (to) begin failures++; $display("FAIL single_drain: got timeout, required idle"); end
        checks++; if ((frames - f0) != 1) begin failures++; $display("FAIL single_frames: got %0d, required 1", frames - f0); end
        checks++;
        if ((start_q.size() != 1) || (start_q[0] != n + 2)) begin
            failures++;
            $display("FAIL single_latency: got %0d starts (first at %0d), required 1 at %0d",
                     start_q.size(), (start_q.size() > 0) ? start_q[0] : -1, n + 2);
        end
    endtask

    task automatic test_burst();
        bit acc, to;
        int nacc = 0, peak = 0, f0;
        start_q.delete();
        f0 = frames;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (int'(bus.fifo_count) > peak) peak = int'(bus.fifo_count);
            offer(8'(i + 1), acc);
            if (acc) nacc++;
        end
        @(negedge clk);
        bus.wr_valid = 1'b0;
        if (int'(bus.fifo_count) > peak) peak = int'(bus.fifo_count);
        checks++; if (nacc != 4) begin failures++; $display("FAIL burst_accepts: got %0d, required 4", nacc); end
        checks++; if (peak != 3) begin failures++; $display("FAIL burst_peak_count: got %0d, required 3", peak); end
        wait_idle(to);
        checks++; if (to) begin failures++; $display("FAIL burst_drain: got timeout, required idle"); end
        checks++; if ((frames - f0) != 4) begin failures++; $display("FAIL burst_frames: got %0d, required 4", frames - f0); end
        checks++;
        if (start_q.size() != 4) begin
            failures++;
            $display("FAIL burst_starts: got %0d, required 4", start_q.size());
        end else if ((start_q[3] - start_q[0]) != 480 || (start_q[1] - start_q[0]) != 160 ||
                     (start_q[2] - start_q[1]) != 160) begin
            failures++;
            $display("FAIL burst_contiguous: got starts %0d %0d %0d %0d, required spacing 160",
                     start_q[0], start_q[1], start_q[2], start_q[3]);
        end
    endtask

    task automatic test_overflow();
        bit acc, to;
        int nacc = 0, f0;
        start_q.delete();
        f0 = frames;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 5) begin
                checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL ovf_before: got %b, required 0", bus.overflow); end
            end
            offer(8'h60 + 8'(i), acc);
            if (acc) nacc++;
        end
        @(negedge clk);
        bus.wr_valid = 1'b0;
        checks++; if (nacc != 5) begin failures++; $display("FAIL ovf_accepts: got %0d, required 5", nacc); end
        checks++; if (bus.overflow !== 1'b1) begin failures++; $display("FAIL ovf_set: got %b, required 1", bus.overflow); end
        wait_idle(to);
        checks++; if (to) begin failures++; $display("FAIL ovf_drain: got timeout, required idle"); end
        checks++; if ((frames - f0) != 5) begin failures++; $display("FAIL ovf_frames: got %0d, required 5", frames - f0); end
        checks++; if (bus.overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky: got %b, required 1", bus.overflow); end
        do_reset();
        @(negedge clk);
        checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL ovf_cleared_by_rst: got %b, required 0", bus.overflow); end
    endtask

    task automatic test_reset_midframe();
        bit acc, to;
        int s, lows = 0, f0;
        start_q.delete();
        @(negedge clk); offer(8'h3C, acc);
        @(negedge clk); offer(8'h11, acc);
        @(negedge clk); offer(8'h22, acc);
        @(negedge clk);
        bus.wr_valid = 1'b0;
        wait_start(to);
        checks++;
        if (to) begin
            failures++;
            $display("FAIL midrst_start: got no start bit, required start bit");
        end else begin
            s = start_q[0];
            checks++; if (bus.fifo_count !== 3'd2) begin failures++; $display("FAIL midrst_queued: got %0d, required 2", bus.fifo_count); end
            at_cycle(s + 4 * CPB + 8);
            checks++; if (bus.tx !== 1'b1) begin failures++; $display("FAIL midrst_bit3: got %b, required 1", bus.tx); end
            rst = 1'b1;
            @(negedge clk);
            checks++; if (bus.tx !== 1'b1) begin failures++; $display("FAIL midrst_tx: got %b, required 1", bus.tx); end
            checks++; if (bus.fifo_count !== 3'd0) begin failures++; $display("FAIL midrst_count: got %0d, required 0", bus.fifo_count); end
            checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL midrst_busy: got %b, required 0", bus.busy); end
        end
        rst = 1'b0;
        exp_q.delete();
        f0 = frames;
        repeat (400) begin
            @(negedge clk);
            if (bus.tx !== 1'b1) lows++;
        end
        checks++; if (lows != 0) begin failures++; $display("FAIL midrst_line_quiet: got %0d low cycles, required 0", lows); end
        checks++; if (frames != f0) begin failures++; $display("FAIL midrst_no_frames: got %0d, required 0", frames - f0); end
    endtask

    task automatic test_ena_drain();
        bit acc, to;
        int nacc = 0, f0;
        start_q.delete();
        f0 = frames;
        @(negedge clk); offer(8'hC1, acc);
        @(negedge clk); offer(8'hC2, acc);
        @(negedge clk); offer(8'hC3, acc);
        @(negedge clk);
        bus.wr_valid = 1'b0;
        bus.ena      = 1'b0;
        checks++; if (bus.fifo_count !== 3'd2) begin failures++; $display("FAIL ena_queued: got %0d, required 2", bus.fifo_count); end
        @(negedge clk);
        checks++; if (bus.wr_ready !== 1'b0) begin failures++; $display("FAIL ena_wr_ready: got %b, required 0", bus.wr_ready); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            offer(8'hEE, acc);
            if (acc) nacc++;
            @(negedge clk);
            bus.wr_valid = 1'b0;
        end
        checks++; if (nacc != 0) begin failures++; $display("FAIL ena_refused: got %0d accepts, required 0", nacc); end
        wait_idle(to);
        checks++; if (to) begin failures++; $display("FAIL ena_drain: got timeout, required idle"); end
        checks++; if ((frames - f0) != 3) begin failures++; $display("FAIL ena_frames: got %0d, required 3", frames - f0); end
        checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL ena_overflow: got %b, required 0", bus.overflow); end
        bus.ena = 1'b1;
    endtask

    task automatic test_full_push_pop();
        bit acc, to;
        int s, f0;
        start_q.delete();
        f0 = frames;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            offer(8'h51 + 8'(i), acc);
        end
        @(negedge clk);
        bus.wr_valid = 1'b0;
        wait_start(to);
        checks++;
        if (to) begin
            failures++;
            $display("FAIL pushpop_start: got no start bit, required start bit");
        end else begin
            s = start_q[0];
            at_cycle(s + 158);
            checks++; if (bus.fifo_count !== 3'd3) begin failures++; $display("FAIL pushpop_pre_count: got %0d, required 3", bus.fifo_count); end
            offer(8'h55, acc);
            checks++; if (acc !== 1'b1) begin failures++; $display("FAIL pushpop_accept: got %b, required 1", acc); end
            at_cycle(s + 159);
            bus.wr_valid = 1'b0;
            checks++; if (bus.fifo_count !== 3'd3) begin failures++; $display("FAIL pushpop_count: got %0d, required 3", bus.fifo_count); end
        end
        bus.wr_valid = 1'b0;
        wait_idle(to);
        checks++; if (to) begin failures++; $display("FAIL pushpop_drain: got timeout, required idle"); end
        checks++; if ((frames - f0) != 5) begin failures++; $display("FAIL pushpop_frames: got %0d, required 5", frames - f0); end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL pushpop_leftover: got %0d pending, required 0", exp_q.size()); end
        checks++;
        if (start_q.size() != 5) begin
            failures++;
            $display("FAIL pushpop_starts: got %0d, required 5", start_q.size());
        end else if ((start_q[4] - start_q[0]) != 640) begin
            failures++;
            $display("FAIL pushpop_contiguous: got span %0d, required 640", start_q[4] - start_q[0]);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_overflow();
        test_reset_midframe();
        test_ena_drain();
        test_full_push_pop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
